// File: rtl/urv_regfile_ctrl_if.sv
// -----------------------------------------------------------------------------
// urv_regfile_ctrl_if
//   Debug-host access channel into the register file controller.
//   The host holds req until it sees a one-cycle ack, then drops req.
//
//   req    host -> ctrl  request, held until ack
//   we     host -> ctrl  1 = write, 0 = read
//   addr   host -> ctrl  register index (x0..x31)
//   wdata  host -> ctrl  write data
//   ack    ctrl -> host  one-cycle completion pulse
//   rdata  ctrl -> host  read data, valid with ack and held afterwards
// -----------------------------------------------------------------------------
interface urv_regfile_ctrl_if;
  logic        req;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/urv_regfile_ctrl.sv
// -----------------------------------------------------------------------------
// urv_regfile_ctrl
//   Sits in front of the dual-bank register file. After reset it writes
//   g_CLEAR_VALUE into x1..x31 (one per cycle), then passes the pipeline's
//   rs1 read and writeback straight through. A debug host can read or write
//   any register; while it does, decode is stalled and the pipeline's rs1
//   read is replayed before the stall is released.
//
//   clk_i, rst_i           clock, synchronous active-low reset
//   d_stall_i, rf_rs1_i    pipeline decode stall and rs1 read address
//   w_rd_*_i               pipeline writeback (address, data, strobe)
//   rs1_raw_i              raw q output of the rs1 bank
//   rf_rs1_o, rf_en1_o     read address / read enable to the banks
//   rf_rd_*_o              write port to the banks (never stores x0)
//   stall_o                registered stall to decode/fetch
//   init_done_o            high once the clear sequence has finished
//   dbg                    debug host channel (slave side)
// -----------------------------------------------------------------------------
module urv_regfile_ctrl #(
  parameter bit          g_CLEAR_ON_RESET = 1'b1,
  parameter logic [31:0] g_CLEAR_VALUE    = 32'h0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 d_stall_i,
  input  logic [4:0]           rf_rs1_i,
  input  logic [4:0]           w_rd_i,
  input  logic [31:0]          w_rd_value_i,
  input  logic                 w_rd_store_i,
  input  logic [31:0]          rs1_raw_i,
  output logic [4:0]           rf_rs1_o,
  output logic                 rf_en1_o,
  output logic [4:0]           rf_rd_o,
  output logic [31:0]          rf_rd_value_o,
  output logic                 rf_rd_store_o,
  output logic                 stall_o,
  output logic                 init_done_o,
  urv_regfile_ctrl_if.slave    dbg
);

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_DBG_ISSUE,
    ST_DBG_RDATA,
    ST_DBG_ACK
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        stall_q, stall_d;
  logic        init_done_q, init_done_d;
  logic [31:0] rdata_q, rdata_d;

  // NOTE: the register RAM itself has no reset; the CLEAR state is what gives
  // x1..x31 a defined value, so only this controller's own flops are reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_i) begin
      state_q     <= g_CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      cnt_q       <= 5'd1;
      stall_q     <= g_CLEAR_ON_RESET;
      init_done_q <= !g_CLEAR_ON_RESET;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_q     <= stall_d;
      init_done_q <= init_done_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    // NOTE: every output and next-state gets a default first so no path
    // through the case statement can infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    stall_d       = stall_q;
    init_done_d   = init_done_q;
    rdata_d       = rdata_q;
    rf_rs1_o      = rf_rs1_i;
    rf_en1_o      = !d_stall_i;
    rf_rd_o       = w_rd_i;
    rf_rd_value_o = w_rd_value_i;
    rf_rd_store_o = w_rd_store_i && (w_rd_i != 5'd0);
    dbg.ack       = 1'b0;

    unique case (state_q)
      ST_CLEAR: begin
        // Pipeline writebacks are dropped: the clear owns the write port.
        rf_rd_o       = cnt_q;
        rf_rd_value_o = g_CLEAR_VALUE;
        rf_rd_store_o = 1'b1;
        cnt_d         = 5'(cnt_q + 5'd1);
        if (cnt_q == 5'd31) begin
          state_d     = ST_IDLE;
          stall_d     = 1'b0;
          init_done_d = 1'b1;
        end
      end

      ST_IDLE: begin
        if (dbg.req) begin
          state_d = ST_DBG_ISSUE;
          stall_d = 1'b1;
        end
      end

      ST_DBG_ISSUE: begin
        // Writeback keeps the write port; the debug access waits for a free
        // cycle, which also keeps a debug read clear of read-during-write.
        if (!w_rd_store_i) begin
          if (dbg.we) begin
            rf_rd_o       = dbg.addr;
            rf_rd_value_o = dbg.wdata;
            rf_rd_store_o = (dbg.addr != 5'd0);
            state_d       = ST_DBG_ACK;
          end else begin
            rf_rs1_o = dbg.addr;
            rf_en1_o = 1'b1;
            state_d  = ST_DBG_RDATA;
          end
        end
      end

      ST_DBG_RDATA: begin
        // Bank q holds the debug read; keep it stable while it is captured.
        rdata_d  = rs1_raw_i;
        rf_en1_o = 1'b0;
        state_d  = ST_DBG_ACK;
      end

      ST_DBG_ACK: begin
        // Replay the pipeline's rs1 read so decode sees its own operand.
        dbg.ack  = 1'b1;
        rf_rs1_o = rf_rs1_i;
        rf_en1_o = 1'b1;
        stall_d  = 1'b0;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        stall_d = 1'b0;
      end
    endcase
  end

  assign stall_o     = stall_q;
  assign init_done_o = init_done_q;
  assign dbg.rdata   = rdata_q;

endmodule

// File: tb/tb_urv_regfile_ctrl.sv
// -----------------------------------------------------------------------------
// tb_urv_regfile_ctrl
//   Drives urv_regfile_ctrl with a register-bank model attached, directed and
//   randomized pipeline/debug traffic. Debug responses are pushed into a
//   scoreboard at request time and popped by a monitor when ack appears.
// -----------------------------------------------------------------------------
module tb_urv_regfile_ctrl;

  localparam logic [31:0] CLR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic        d_stall_i;
  logic [4:0]  rf_rs1_i;
  logic [4:0]  w_rd_i;
  logic [31:0] w_rd_value_i;
  logic        w_rd_store_i;
  logic [31:0] rs1_raw_i;
  logic [4:0]  rf_rs1_o;
  logic        rf_en1_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_rd_value_o;
  logic        rf_rd_store_o;
  logic        stall_o;
  logic        init_done_o;

  urv_regfile_ctrl_if dbg_if ();

  urv_regfile_ctrl #(
    .g_CLEAR_ON_RESET (1'b1),
    .g_CLEAR_VALUE    (CLR)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .d_stall_i     (d_stall_i),
    .rf_rs1_i      (rf_rs1_i),
    .w_rd_i        (w_rd_i),
    .w_rd_value_i  (w_rd_value_i),
    .w_rd_store_i  (w_rd_store_i),
    .rs1_raw_i     (rs1_raw_i),
    .rf_rs1_o      (rf_rs1_o),
    .rf_en1_o      (rf_en1_o),
    .rf_rd_o       (rf_rd_o),
    .rf_rd_value_o (rf_rd_value_o),
    .rf_rd_store_o (rf_rd_store_o),
    .stall_o       (stall_o),
    .init_done_o   (init_done_o),
    .dbg           (dbg_if.slave)
  );

  // Register bank: x0 hardwired to zero, synchronous read with enable.
  logic [31:0] bank_mem [32];
  logic [31:0] bank_q;
  always @(posedge clk) begin
    if (rf_rd_store_o && rf_rd_o != 5'd0) bank_mem[rf_rd_o] <= rf_rd_value_o;
    if (rf_en1_o) bank_q <= (rf_rs1_o == 5'd0) ? 32'h0 : bank_mem[rf_rs1_o];
  end
  assign rs1_raw_i = bank_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: architectural register contents.
  logic [31:0] ref_rf [32];
  logic [31:0] last_rdata;

  typedef struct {
    logic        we;
    logic [31:0] data;
    int          issue;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: x0 is never stored; debug acks are matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_i) begin
      check("x0_store", 32'(rf_rd_store_o && rf_rd_o == 5'd0), 32'd0);
      if (dbg_if.ack) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          if (!e.we) check("dbg_rdata", dbg_if.rdata, e.data);
          check("dbg_latency", 32'(cyc - e.issue + 1), 32'(e.lat));
          check("replay_addr", 32'(rf_rs1_o), 32'(rf_rs1_i));
          check("replay_en", 32'(rf_en1_o), 32'd1);
          check("ack_stall", 32'(stall_o), 32'd1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts at +1 after the first edge with reset released (clear cycle 1).
  task automatic check_clear();
    for (int i = 1; i <= 31; i++) begin
      w_rd_i       = 5'd9;
      w_rd_value_i = $urandom;
      w_rd_store_i = 1'b1;
      #1;
      check("clr_addr", 32'(rf_rd_o), 32'(i));
      check("clr_data", rf_rd_value_o, CLR);
      check("clr_store", 32'(rf_rd_store_o), 32'd1);
      check("clr_stall", 32'(stall_o), 32'd1);
      check("clr_done", 32'(init_done_o), 32'd0);
      tick();
    end
    w_rd_store_i = 1'b0;
    for (int i = 1; i < 32; i++) ref_rf[i] = CLR;
    #1;
    check("clr_done_rise", 32'(init_done_o), 32'd1);
    check("clr_stall_fall", 32'(stall_o), 32'd0);
    tick();
  endtask

  task automatic do_reset();
    rst_i        = 1'b0;
    w_rd_store_i = 1'b0;
    dbg_if.req   = 1'b0;
    tick();
    tick();
    check("rst_ack", 32'(dbg_if.ack), 32'd0);
    check("rst_rdata", dbg_if.rdata, 32'd0);
    check("rst_stall", 32'(stall_o), 32'd1);
    check("rst_done", 32'(init_done_o), 32'd0);
    rst_i = 1'b1;
    sb.delete();
    last_rdata = 32'h0;
    check_clear();
  endtask

  task automatic idle_step(input logic [4:0] rd, input logic [31:0] val,
                           input logic st, input logic [4:0] rs1, input logic dst);
    w_rd_i       = rd;
    w_rd_value_i = val;
    w_rd_store_i = st;
    rf_rs1_i     = rs1;
    d_stall_i    = dst;
    #1;
    check("idle_rd", 32'(rf_rd_o), 32'(rd));
    check("idle_val", rf_rd_value_o, val);
    check("idle_store", 32'(rf_rd_store_o), 32'(st && rd != 5'd0));
    check("idle_rs1", 32'(rf_rs1_o), 32'(rs1));
    check("idle_en1", 32'(rf_en1_o), 32'(!dst));
    if (st && rd != 5'd0) ref_rf[rd] = val;
    tick();
    w_rd_store_i = 1'b0;
    d_stall_i    = 1'b0;
  endtask

  task automatic dbg_txn(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rs1, input int ncoll);
    logic [4:0]  crd  [4];
    logic [31:0] cval [4];
    exp_t        e;
    int          t;
    rf_rs1_i     = rs1;
    d_stall_i    = 1'b0;
    w_rd_store_i = 1'b0;
    for (int k = 0; k < ncoll; k++) begin
      crd[k]  = 5'($urandom_range(0, 31));
      cval[k] = $urandom;
      if (crd[k] != 5'd0) ref_rf[crd[k]] = cval[k];
    end
    e.we = we;
    if (we) begin
      if (addr != 5'd0) ref_rf[addr] = wdata;
      e.data = 32'h0;
    end else begin
      e.data     = (addr == 5'd0) ? 32'h0 : ref_rf[addr];
      last_rdata = e.data;
    end
    e.issue = cyc + 1;
    e.lat   = ncoll + (we ? 2 : 3);
    sb.push_back(e);
    dbg_if.req   = 1'b1;
    dbg_if.we    = we;
    dbg_if.addr  = addr;
    dbg_if.wdata = wdata;
    tick();
    for (int k = 0; k < ncoll; k++) begin
      w_rd_i       = crd[k];
      w_rd_value_i = cval[k];
      w_rd_store_i = 1'b1;
      tick();
    end
    w_rd_store_i = 1'b0;
    t = 0;
    while (dbg_if.ack !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    if (t == 20) begin
      check("ack_timeout", 32'd0, 32'd1);
      sb.delete();
    end
    tick();
    dbg_if.req = 1'b0;
    #1;
    check("post_stall", 32'(stall_o), 32'd0);
    check("rdata_held", dbg_if.rdata, last_rdata);
    check("replay_q", bank_q, (rs1 == 5'd0) ? 32'h0 : ref_rf[rs1]);
    tick();
  endtask

  // Reset lands while the controller is capturing debug read data.
  task automatic reset_mid_rdata();
    rf_rs1_i    = 5'd3;
    dbg_if.req  = 1'b1;
    dbg_if.we   = 1'b0;
    dbg_if.addr = 5'd5;
    tick();
    tick();
    rst_i      = 1'b0;
    dbg_if.req = 1'b0;
    tick();
    check("mid_rst_ack", 32'(dbg_if.ack), 32'd0);
    check("mid_rst_rdata", dbg_if.rdata, 32'd0);
    check("mid_rst_addr", 32'(rf_rd_o), 32'd1);
    check("mid_rst_done", 32'(init_done_o), 32'd0);
    rst_i = 1'b1;
    sb.delete();
    last_rdata = 32'h0;
    check_clear();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i        = 1'b0;
    d_stall_i    = 1'b0;
    rf_rs1_i     = 5'd0;
    w_rd_i       = 5'd0;
    w_rd_value_i = 32'h0;
    w_rd_store_i = 1'b0;
    dbg_if.req   = 1'b0;
    dbg_if.we    = 1'b0;
    dbg_if.addr  = 5'd0;
    dbg_if.wdata = 32'h0;
    ref_rf[0]    = 32'h0;
    last_rdata   = 32'h0;
    #2;
    do_reset();

    idle_step(5'd5, 32'h1234, 1'b1, 5'd0, 1'b0);
    idle_step(5'd0, 32'hFFFF, 1'b1, 5'd0, 1'b0);
    dbg_txn(1'b1, 5'd7, 32'hA5A5A5A5, 5'd0, 2);
    dbg_txn(1'b0, 5'd7, 32'h0, 5'd0, 0);
    dbg_txn(1'b0, 5'd5, 32'h0, 5'd3, 0);
    dbg_txn(1'b1, 5'd0, 32'h55, 5'd1, 0);
    dbg_txn(1'b0, 5'd0, 32'h0, 5'd2, 0);

    repeat (40) idle_step(5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    repeat (25) dbg_txn(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                        5'($urandom_range(0, 31)), int'($urandom_range(0, 3)));

    reset_mid_rdata();
    repeat (10) dbg_txn(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                        5'($urandom_range(0, 31)), int'($urandom_range(0, 3)));

    tick();
    for (int i = 1; i < 32; i++) check("bank_contents", bank_mem[i], ref_rf[i]);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/urv_regfile_ctrl.md
Name: urv_regfile_ctrl

Overview:
Controller in front of the dual-bank register file. It sequences a post-reset clear of x1..x31, because the register RAM has no reset. It also shares the register file's write port and rs1 read port between pipeline writeback and a debug host. While it owns the register file it stalls the decode stage, and before releasing the stall it replays the pipeline's rs1 read.

Parameters:
g_CLEAR_ON_RESET, 1, 1 = run the 31-cycle clear sequence after reset; 0 = go straight to IDLE.
g_CLEAR_VALUE, 32'h0, value written to x1..x31 during clear.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-low reset
d_stall_i  in  1  pipeline decode stall
rf_rs1_i  in  5  pipeline rs1 read address
w_rd_i  in  5  pipeline writeback register
w_rd_value_i  in  32  pipeline writeback data
w_rd_store_i  in  1  pipeline writeback strobe
rs1_raw_i  in  32  rs1 bank raw q output (pre-bypass)
rf_rs1_o  out  5  read address to rs1 bank
rf_en1_o  out  1  read enable to both banks
rf_rd_o  out  5  write address to banks
rf_rd_value_o  out  32  write data to banks
rf_rd_store_o  out  1  write strobe to banks (never asserted for x0)
stall_o  out  1  registered; stalls decode/fetch
init_done_o  out  1  high once clear is finished
dbg_req_i  in  1  debug request, held until ack
dbg_we_i  in  1  1 = write, 0 = read
dbg_addr_i  in  5  debug register index
dbg_wdata_i  in  32  debug write data
dbg_ack_o  out  1  one-cycle completion pulse
dbg_rdata_o  out  32  debug read data, valid with ack and held afterwards

Behaviour:
- Reset (rst_i low at clk edge): state := CLEAR (IDLE if g_CLEAR_ON_RESET=0); clear counter := 1; stall_o=1 (0 if no clear); init_done_o=0 (1 if no clear); dbg_ack_o=0; dbg_rdata_o=0. Any pending debug transaction is discarded.
- CLEAR:
  - rf_rd_o=counter, rf_rd_value_o=g_CLEAR_VALUE, rf_rd_store_o=1, one register per cycle, x1 first.
  - Pipeline writebacks are ignored in this state.
  - After x31 is written: state→IDLE, stall_o:=0, init_done_o:=1. Clear takes exactly 31 cycles after reset release.
  - dbg_req_i is not serviced until IDLE.
- IDLE (passthrough):
  - rf_rs1_o=rf_rs1_i, rf_en1_o=!d_stall_i.
  - rf_rd_o/rf_rd_value_o follow w_rd_i/w_rd_value_i.
  - rf_rd_store_o = w_rd_store_i && w_rd_i!=0.
  - If dbg_req_i is high: state→DBG_ISSUE, stall_o:=1 from the next cycle.
- DBG_ISSUE:
  - Pipeline writeback keeps priority on the write port and passes through as in IDLE.
  - If w_rd_store_i=0:
    - Write request: drive dbg_addr_i/dbg_wdata_i on the write port with store = dbg_addr_i!=0; state→DBG_ACK.
    - Read request: rf_rs1_o=dbg_addr_i, rf_en1_o=1; state→DBG_RDATA.
  - If w_rd_store_i=1, stay in DBG_ISSUE.
  - Waiting for a free cycle guarantees no read-during-write on the debug read.
- DBG_RDATA: dbg_rdata_o := rs1_raw_i; rf_en1_o=0; state→DBG_ACK.
- DBG_ACK:
  - dbg_ack_o=1 for exactly this cycle.
  - Replay read: rf_rs1_o=rf_rs1_i, rf_en1_o=1, restoring the pipeline operand. The replay happens on writes too.
  - stall_o:=0 at the next edge; state→IDLE.
- Handshake: the requester deasserts dbg_req_i in the cycle after ack. If req is still high in IDLE, it is treated as a new request.
- Writeback passthrough stays active in all DBG states, so no writeback is lost while stalled.
- Debug read of x0 returns whatever the bank holds (0 after clear). Debug write to x0 is acked with no store.
- Latency with no writeback collision: write = ack 2 cycles after req sampled in IDLE; read = 3 cycles.

Test Plan:
- Reset, g_CLEAR_ON_RESET=1, g_CLEAR_VALUE=32'hDEADBEEF → 31 consecutive stores, x1..x31 = DEADBEEF; init_done_o rises on cycle 32; stall_o falls the same cycle.
- IDLE, pipeline writes x5=32'h1234 then x0=32'hFFFF → x5 is stored; rf_rd_store_o stays 0 for x0.
- Debug write x7=32'hA5A5A5A5 while w_rd_store_i is high for 2 cycles in DBG_ISSUE → pipeline writes complete first; debug write follows; ack 2 cycles after collisions end; x7 reads back A5A5A5A5.
- Debug read x5 (=32'h1234) with pipeline rf_rs1_i=3 held → dbg_rdata_o=1234 with ack; in the ack cycle rf_rs1_o=3 with rf_en1_o=1; after the stall drops, rs1 q = x3.
- Debug write x0=32'h55 → ack asserted; no store; x0 reads 0.
- rst_i low while in DBG_RDATA → no ack; state CLEAR; clear sequence restarts from x1; dbg_rdata_o=0.
